// File: rtl/att_pkg.sv
// Shared types, default timing constants and helpers for the step-attenuator
// write scheduler and its round-robin arbiter.
package att_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    LATCH  = 2'd2,
    SETTLE = 2'd3
  } att_state_e;

  localparam int ATT_DATA_W     = 16;
  localparam int ATT_CLK_DIV    = 4;     // clock cycles per serial CLK half-period
  localparam int ATT_LE_CYC     = 2;     // LE high width in clock cycles
  localparam int ATT_SETTLE_CYC = 4000;  // 40 us at 100 MHz

  // Bits needed to index n items; never less than 1 so vectors stay legal.
  function automatic int att_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/att_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the
// pointer, wrapping modulo N_REQ.
module att_rr_arbiter
  import att_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = att_clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic             o_any,
  output logic [ID_W-1:0]  o_idx,
  output logic [N_REQ-1:0] o_grant
);

  // Walk the requesters starting at the pointer; the first hit wins.
  always_comb begin
    logic [ID_W:0] pos;
    o_any   = 1'b0;
    o_idx   = '0;
    o_grant = '0;
    pos     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = {1'b0, i_ptr} + (ID_W+1)'(k);
      if (pos >= (ID_W+1)'(N_REQ)) pos = pos - (ID_W+1)'(N_REQ);
      if (!o_any && i_req[pos[ID_W-1:0]]) begin
        o_any = 1'b1;
        o_idx = pos[ID_W-1:0];
      end
    end
    if (o_any) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/att_write_scheduler.sv
// Shares one serial step-attenuator port (SI/CLK/LE, LSB first) between
// N_REQ requesters. Each write is shift -> LE pulse -> settle window; only
// one write is in flight. Pins are registered so they never glitch.
module att_write_scheduler
  import att_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = ATT_DATA_W,
  parameter int CLK_DIV    = ATT_CLK_DIV,
  parameter int LE_CYC     = ATT_LE_CYC,
  parameter int SETTLE_CYC = ATT_SETTLE_CYC
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_W-1:0]       req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          busy,
  output logic [att_clog2(N_REQ)-1:0]   grant_id,
  output logic                          done_pulse,
  output logic [DATA_W-1:0]             last_word,
  output logic                          SI,
  output logic                          CLK,
  output logic                          LE
);

  localparam int ID_W  = att_clog2(N_REQ);
  localparam int DIV_W = att_clog2(2*CLK_DIV) + 1;
  localparam int BIT_W = att_clog2(DATA_W) + 1;
  localparam int LE_W  = att_clog2(LE_CYC) + 1;
  localparam int SET_W = att_clog2(SETTLE_CYC) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2*CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(CLK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [LE_W-1:0]  LE_LAST  = LE_W'(LE_CYC - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  att_state_e        r_state, w_state_next;
  logic [DATA_W-1:0] r_shift, w_shift_next;
  logic [DATA_W-1:0] r_word, r_last_word;
  logic [DIV_W-1:0]  r_div_cnt, w_div_next;
  logic [BIT_W-1:0]  r_bit_cnt, w_bit_next;
  logic [LE_W-1:0]   r_le_cnt, w_le_next;
  logic [SET_W-1:0]  r_settle_cnt, w_settle_next;
  logic              r_redundant, w_redundant_next;
  logic              r_written, r_busy, r_si, r_clk, r_le;
  logic [ID_W-1:0]   r_grant_id, r_rr_ptr;

  logic              w_any, w_accept, w_redundant_hit, w_settle_done;
  logic [ID_W-1:0]   w_win_idx;
  logic [N_REQ-1:0]  w_win_onehot;
  logic [DATA_W-1:0] w_req_word;
  logic              w_si_next, w_clk_next, w_le_next_pin;

  att_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_any   (w_any),
    .o_idx   (w_win_idx),
    .o_grant (w_win_onehot)
  );

  assign w_req_word      = req_data[w_win_idx*DATA_W +: DATA_W];
  assign w_accept        = (r_state == IDLE) && w_any;
  // Rewriting the word already in the attenuator skips the pins entirely.
  assign w_redundant_hit = r_written && (w_req_word == r_last_word);
  assign w_settle_done   = (r_state == SETTLE) &&
                           (r_redundant || (r_settle_cnt >= SET_LAST));

  // Next-state, counter and pin-value logic for the write sequencer.
  always_comb begin
    w_state_next     = r_state;
    w_shift_next     = r_shift;
    w_div_next       = r_div_cnt;
    w_bit_next       = r_bit_cnt;
    w_le_next        = r_le_cnt;
    w_settle_next    = r_settle_cnt;
    w_redundant_next = r_redundant;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_next     = w_redundant_hit ? SETTLE : SHIFT;
          w_shift_next     = w_req_word;
          w_div_next       = '0;
          w_bit_next       = '0;
          w_settle_next    = '0;
          w_redundant_next = w_redundant_hit;
        end
      end
      SHIFT: begin
        if (r_div_cnt >= DIV_LAST) begin
          w_div_next = '0;
          if (r_bit_cnt >= BIT_LAST) begin
            w_state_next = LATCH;
            w_le_next    = '0;
          end else begin
            w_bit_next   = r_bit_cnt + BIT_W'(1);
            w_shift_next = r_shift >> 1;
          end
        end else begin
          w_div_next = r_div_cnt + DIV_W'(1);
        end
      end
      LATCH: begin
        if (r_le_cnt >= LE_LAST) begin
          w_state_next  = SETTLE;
          w_settle_next = '0;
        end else begin
          w_le_next = r_le_cnt + LE_W'(1);
        end
      end
      SETTLE: begin
        if (w_settle_done) begin
          w_state_next     = IDLE;
          w_redundant_next = 1'b0;
        end else begin
          w_settle_next = r_settle_cnt + SET_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
    w_si_next     = (w_state_next == SHIFT) && w_shift_next[0];
    w_clk_next    = (w_state_next == SHIFT) && (w_div_next >= DIV_HIGH);
    w_le_next_pin = (w_state_next == LATCH);
  end

  // State, counters, pins and bookkeeping; reset drops every pin at once.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_word       <= '0;
      r_last_word  <= '0;
      r_div_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_le_cnt     <= '0;
      r_settle_cnt <= '0;
      r_redundant  <= 1'b0;
      r_written    <= 1'b0;
      r_busy       <= 1'b0;
      r_si         <= 1'b0;
      r_clk        <= 1'b0;
      r_le         <= 1'b0;
      r_grant_id   <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_shift      <= w_shift_next;
      r_div_cnt    <= w_div_next;
      r_bit_cnt    <= w_bit_next;
      r_le_cnt     <= w_le_next;
      r_settle_cnt <= w_settle_next;
      r_redundant  <= w_redundant_next;
      r_busy       <= (w_state_next != IDLE);
      r_si         <= w_si_next;
      r_clk        <= w_clk_next;
      r_le         <= w_le_next_pin;
      if (w_accept) begin
        r_word     <= w_req_word;
        r_grant_id <= w_win_idx;
        r_rr_ptr   <= (w_win_idx == ID_LAST) ? '0 : w_win_idx + ID_W'(1);
      end
      // last_word reflects what the LE pulse about to fire will latch.
      if ((r_state == SHIFT) && (w_state_next == LATCH)) begin
        r_last_word <= r_word;
        r_written   <= 1'b1;
      end
    end
  end

  assign req_ready  = (S_AXI_ARESETN && (r_state == IDLE)) ? w_win_onehot : '0;
  assign busy       = r_busy;
  assign grant_id   = r_grant_id;
  assign done_pulse = w_settle_done;
  assign last_word  = r_last_word;
  assign SI         = r_si;
  assign CLK        = r_clk;
  assign LE         = r_le;

endmodule

// File: tb/tb_att_write_scheduler.sv
// Self-checking bench: a cycle-time model (time since accept -> pin values)
// checks both DUT instances every cycle; directed tests add literal checks.
module tb_att_write_scheduler;

  localparam int NR = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: default timing. Instance 1: CLK_DIV=1, SETTLE_CYC=1.
  logic        rst0_n, rst1_n;
  logic [3:0]  rv0, rv1, rdy0, rdy1, seen0, seen1;
  logic [63:0] rd0, rd1;
  logic        busy0, busy1, dn0, dn1, si0, si1, sclk0, sclk1, le0, le1;
  logic [1:0]  gid0, gid1;
  logic [15:0] lw0, lw1;
  bit          ad0, ad1;

  att_write_scheduler #(.N_REQ(NR), .DATA_W(DW), .CLK_DIV(4), .LE_CYC(2), .SETTLE_CYC(4000)) dut0 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst0_n), .req_valid(rv0), .req_data(rd0),
    .req_ready(rdy0), .busy(busy0), .grant_id(gid0), .done_pulse(dn0),
    .last_word(lw0), .SI(si0), .CLK(sclk0), .LE(le0));

  att_write_scheduler #(.N_REQ(NR), .DATA_W(DW), .CLK_DIV(1), .LE_CYC(2), .SETTLE_CYC(1)) dut1 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst1_n), .req_valid(rv1), .req_data(rd1),
    .req_ready(rdy1), .busy(busy1), .grant_id(gid1), .done_pulse(dn1),
    .last_word(lw1), .SI(si1), .CLK(sclk1), .LE(le1));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int p_cd[2] = '{4, 1};
  int p_le[2] = '{2, 2};
  int p_st[2] = '{4000, 1};

  // Model: m_t = cycles since accept (0 = idle).
  int          m_t[2], m_rr[2], m_grant[2];
  logic [15:0] m_word[2], m_lw[2];
  bit          m_red[2], m_wr[2];

  // Event recorders.
  int          r_acc_n[2], r_done_n[2], r_rises[2], r_le_n[2], r_pin_n[2];
  int          r_acc_last[2], r_done_last[2], r_first_rise[2], r_last_rise[2];
  int          r_le_first[2], r_le_last[2];
  logic [15:0] r_bits[2], r_word_last[2];
  logic        prev_clk[2], prev_le[2];
  int          q_grant[$], q_acc[$], q_done[$];
  logic [15:0] q_word[$];

  task automatic clear_rec(input int k);
    r_acc_n[k] = 0; r_done_n[k] = 0; r_rises[k] = 0; r_le_n[k] = 0; r_pin_n[k] = 0;
    r_acc_last[k] = 0; r_done_last[k] = 0; r_first_rise[k] = 0; r_last_rise[k] = 0;
    r_le_first[k] = 0; r_le_last[k] = 0; r_bits[k] = '0; r_word_last[k] = '0;
    if (k == 0) begin
      q_grant.delete(); q_acc.delete(); q_done.delete(); q_word.delete();
    end
  endtask

  task automatic check_inst(input int k, input logic rst, input logic [3:0] rv,
                            input logic [63:0] rd, input logic [3:0] rdy, input logic bsy,
                            input logic [1:0] gid, input logic dn, input logic [15:0] lw,
                            input logic si_v, input logic clk_v, input logic le_v);
    logic [3:0]  e_rdy;
    logic        e_bsy, e_dn, e_si, e_clk, e_le;
    logic [1:0]  e_gid;
    logic [15:0] e_lw;
    logic [26:0] e_vec, a_vec;
    int sl, fin, win, idx;
    sl  = DW * 2 * p_cd[k];
    fin = m_red[k] ? 1 : sl + p_le[k] + p_st[k];
    e_rdy = '0; e_bsy = 0; e_dn = 0; e_si = 0; e_clk = 0; e_le = 0;
    e_gid = 2'(m_grant[k]);
    e_lw  = m_lw[k];
    win   = -1;
    if (!rst) begin
      e_gid = '0;
      e_lw  = '0;
    end else if (m_t[k] == 0) begin
      for (int j = 0; j < NR; j++)
        if (win < 0 && rv[(m_rr[k] + j) % NR]) win = (m_rr[k] + j) % NR;
      if (win >= 0) e_rdy[win] = 1'b1;
    end else begin
      e_bsy = 1'b1;
      e_dn  = (m_t[k] == fin);
      if (!m_red[k]) begin
        if (m_t[k] <= sl) begin
          e_si  = m_word[k][(m_t[k] - 1) / (2 * p_cd[k])];
          e_clk = ((m_t[k] - 1) % (2 * p_cd[k])) >= p_cd[k];
        end else if (m_t[k] <= sl + p_le[k]) begin
          e_le = 1'b1;
        end
      end
    end
    e_vec = {e_rdy, e_bsy, e_gid, e_dn, e_lw, e_si, e_clk, e_le};
    a_vec = {rdy, bsy, gid, dn, lw, si_v, clk_v, le_v};
    n_tests++;
    if (a_vec !== e_vec) begin
      n_fail++;
      $display("FAIL outputs inst%0d cyc%0d: got rdy=%b busy=%b gid=%0d done=%b lw=%h si=%b clk=%b le=%b, expected rdy=%b busy=%b gid=%0d done=%b lw=%h si=%b clk=%b le=%b",
               k, cyc, rdy, bsy, gid, dn, lw, si_v, clk_v, le_v,
               e_rdy, e_bsy, e_gid, e_dn, e_lw, e_si, e_clk, e_le);
    end
    // Record observed events for the directed checks.
    if (rdy != 0) begin
      idx = 0;
      for (int j = 0; j < NR; j++) if (rdy[j]) idx = j;
      r_acc_n[k]++; r_acc_last[k] = cyc;
      if (k == 0) begin q_grant.push_back(idx); q_acc.push_back(cyc); end
    end
    if (dn) begin
      r_done_n[k]++; r_done_last[k] = cyc;
      if (k == 0) q_done.push_back(cyc);
    end
    if (clk_v && !prev_clk[k]) begin
      r_rises[k]++;
      if (r_rises[k] == 1) r_first_rise[k] = cyc;
      r_last_rise[k] = cyc;
      r_bits[k] = {si_v, r_bits[k][15:1]};
    end
    if (le_v) begin
      r_le_n[k]++;
      if (!prev_le[k]) begin
        r_le_first[k] = cyc; r_word_last[k] = r_bits[k];
        if (k == 0) q_word.push_back(r_bits[k]);
      end
      r_le_last[k] = cyc;
    end
    if (si_v || clk_v || le_v) r_pin_n[k]++;
    prev_clk[k] = clk_v;
    prev_le[k]  = le_v;
    // Advance the model to the next cycle.
    if (!rst) begin
      m_t[k] = 0; m_rr[k] = 0; m_grant[k] = 0; m_lw[k] = '0; m_wr[k] = 0; m_red[k] = 0;
    end else if (m_t[k] == 0) begin
      if (win >= 0) begin
        m_grant[k] = win;
        m_rr[k]    = (win + 1) % NR;
        m_word[k]  = rd[win*DW +: DW];
        m_red[k]   = m_wr[k] && (m_word[k] == m_lw[k]);
        m_t[k]     = 1;
      end
    end else if (m_t[k] == fin) begin
      m_t[k] = 0;
    end else begin
      m_t[k]++;
      if (!m_red[k] && m_t[k] == sl + 1) begin
        m_lw[k] = m_word[k];
        m_wr[k] = 1;
      end
    end
  endtask

  // One clock: check at the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    seen0 = rdy0;
    seen1 = rdy1;
    check_inst(0, rst0_n, rv0, rd0, rdy0, busy0, gid0, dn0, lw0, si0, sclk0, le0);
    check_inst(1, rst1_n, rv1, rd1, rdy1, busy1, gid1, dn1, lw1, si1, sclk1, le1);
    @(posedge clk);
    #1;
    if (ad0) rv0 = rv0 & ~seen0;
    if (ad1) rv1 = rv1 & ~seen1;
  endtask

  function automatic int get_cnt(input int k, input int kind);
    case (kind)
      0:       return r_acc_n[k];
      1:       return r_done_n[k];
      default: return r_rises[k];
    endcase
  endfunction

  task automatic run_until(input int k, input int kind, input int target, input int budget,
                           input string name);
    int n;
    n = 0;
    while (get_cnt(k, kind) < target && n < budget) begin
      tick();
      n++;
    end
    n_tests++;
    if (get_cnt(k, kind) < target) begin
      n_fail++;
      $display("FAIL %s: count %0d after %0d cycles, needed %0d", name, get_cnt(k, kind), n, target);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic pulse_reset0();
    rst0_n = 1'b0;
    tick();
    rst0_n = 1'b1;
    tick();
  endtask

  int          exp_grants[5] = '{0, 1, 2, 3, 0};
  logic [15:0] words[4]      = '{16'h0F0F, 16'hF00D, 16'h8001, 16'h7E7E};
  int          si_seq[16]    = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
  logic [15:0] seq_word;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_t[k] = 0; m_rr[k] = 0; m_grant[k] = 0; m_word[k] = '0; m_lw[k] = '0;
      m_red[k] = 0; m_wr[k] = 0; prev_clk[k] = 0; prev_le[k] = 0;
      clear_rec(k);
    end
    rst0_n = 0; rst1_n = 0; rv0 = 0; rv1 = 0; rd0 = 0; rd1 = 0; ad0 = 1; ad1 = 1;
    seen0 = 0; seen1 = 0;
    repeat (3) tick();
    rst0_n = 1; rst1_n = 1;
    tick();
    chk("reset busy", int'(busy0), 0);
    chk("reset last_word", int'(lw0), 0);
    chk("reset grant_id", int'(gid0), 0);

    // Single write from requester 0.
    clear_rec(0);
    rd0[15:0] = 16'hA5C3;
    rv0 = 4'b0001;
    run_until(0, 1, 1, 5000, "single done");
    tick();
    seq_word = '0;
    for (int i = 0; i < 16; i++) seq_word[i] = 1'(si_seq[i]);
    chk("single ready cycles", r_acc_n[0], 1);
    chk("single SI sequence", int'(r_word_last[0]), int'(seq_word));
    chk("single CLK rises", r_rises[0], 16);
    chk("single first rise offset", r_first_rise[0] - r_acc_last[0], 5);
    chk("single rise span", r_last_rise[0] - r_first_rise[0], 120);
    chk("single LE width", r_le_n[0], 2);
    chk("single settle", r_done_last[0] - r_le_last[0], 4000);
    chk("single accept to done", r_done_last[0] - r_acc_last[0], 4130);
    chk("single last_word", int'(lw0), 16'hA5C3);

    // Contention: all four requesters held valid.
    pulse_reset0();
    clear_rec(0);
    ad0 = 0;
    for (int i = 0; i < 4; i++) rd0[i*16 +: 16] = words[i];
    rv0 = 4'hF;
    run_until(0, 0, 5, 5 * 4200, "contention accepts");
    rv0 = 4'h0;
    run_until(0, 1, 5, 4200, "contention done");
    tick();
    ad0 = 1;
    chk("contention grant count", q_grant.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("contention grant %0d", i), q_grant[i], exp_grants[i]);
      chk($sformatf("contention word %0d", i), int'(q_word[i]), int'(words[exp_grants[i]]));
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("contention gap %0d", i), q_acc[i+1] - q_done[i], 1);

    // Request arriving mid-shift is held off until the idle cycle.
    clear_rec(0);
    rd0[16 +: 16] = 16'h1357;
    rd0[32 +: 16] = 16'h2468;
    rv0 = 4'b0010;
    run_until(0, 2, 3, 200, "busy mid-shift");
    rv0[2] = 1'b1;
    run_until(0, 0, 2, 4300, "busy second accept");
    chk("busy first grant", q_grant[0], 1);
    chk("busy second grant", q_grant[1], 2);
    chk("busy accept after done", q_acc[1] - q_done[0], 1);
    run_until(0, 1, 2, 4300, "busy second done");
    tick();

    // Redundant write from requester 3.
    clear_rec(0);
    rd0[48 +: 16] = 16'h0010;
    rv0 = 4'b1000;
    run_until(0, 1, 1, 4300, "redundant first done");
    clear_rec(0);
    rv0 = 4'b1000;
    run_until(0, 1, 1, 20, "redundant second done");
    repeat (2) tick();
    chk("redundant pin activity", r_pin_n[0], 0);
    chk("redundant done latency", r_done_last[0] - r_acc_last[0], 1);
    chk("redundant last_word", int'(lw0), 16'h0010);

    // Reset during the shift of bit 8.
    clear_rec(0);
    rd0[15:0] = 16'hFFFF;
    rv0 = 4'b0001;
    run_until(0, 2, 9, 200, "reset mid-shift rises");
    chk("pre-reset CLK", int'(sclk0), 1);
    chk("pre-reset SI", int'(si0), 1);
    rst0_n = 1'b0;
    #1;
    chk("reset pins", int'({si0, sclk0, le0, busy0}), 0);
    tick();
    chk("reset last_word cleared", int'(lw0), 0);
    chk("reset no LE", r_le_n[0], 0);
    rst0_n = 1'b1;
    tick();
    clear_rec(0);
    rd0[32 +: 16] = 16'h5A0F;
    rv0 = 4'b0100;
    run_until(0, 1, 1, 4300, "post-reset done");
    tick();
    chk("post-reset grant", q_grant[0], 2);
    chk("post-reset shifted word", int'(r_word_last[0]), 16'h5A0F);
    chk("post-reset last_word", int'(lw0), 16'h5A0F);

    // Fast timing instance.
    clear_rec(1);
    rd1[16 +: 16] = 16'hBEEF;
    rv1 = 4'b0010;
    run_until(1, 1, 1, 200, "fast done");
    tick();
    chk("fast CLK rises", r_rises[1], 16);
    chk("fast shift length", r_le_first[1] - r_acc_last[1] - 1, 32);
    chk("fast settle", r_done_last[1] - r_le_last[1], 1);
    chk("fast shifted word", int'(r_word_last[1]), 16'hBEEF);
    chk("fast last_word", int'(lw1), 16'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/att_write_scheduler.md
Name: att_write_scheduler

Overview:
- Shares one serial step-attenuator port (SI/CLK/LE, 16-bit word, LSB first) between N_REQ requesters.
- Requesters are AXI register banks or the AGC loop. Arbitration is round-robin.
- Sequences each write as shift, then latch pulse, then enforced settle window. One write is in flight at a time.
- Sits in the S_AXI_ACLK domain; drives the attenuator pins directly.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 16, attenuator word width.
- CLK_DIV, 4, S_AXI_ACLK cycles per CLK half-period (>=1).
- LE_CYC, 2, LE high width in cycles (>=1).
- SETTLE_CYC, 4000, post-latch settle window in cycles (40 us at 100 MHz; >=1).

Ports:
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester write request; held until accepted.
- req_data  in  N_REQ*DATA_W  request words; requester i owns slice [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot accept pulse, 1 cycle.
- busy  out  1  high from accept until done_pulse inclusive.
- grant_id  out  clog2(N_REQ)  index of the current/last granted requester.
- done_pulse  out  1  1-cycle pulse when the settle window ends.
- last_word  out  DATA_W  last word latched into the attenuator.
- SI  out  1  serial data.
- CLK  out  1  serial clock.
- LE  out  1  latch enable.

Behaviour:
- Reset: state IDLE, rr pointer 0. All outputs 0, including last_word. Reset is asynchronous: asserting it mid-write drops SI/CLK/LE immediately. The partially shifted word is discarded and never latched.

State IDLE:
- If any req_valid is set, pick the first set bit at or after the rr pointer, wrapping modulo N_REQ.
- In that same cycle, assert req_ready[winner] combinationally and capture the word into the shift register.
- On that edge, set grant_id = winner, rr pointer = winner+1 mod N_REQ, busy = 1, and go to SHIFT.
- With no req_valid set, stay in IDLE; req_ready stays 0.

State SHIFT:
- Shifts DATA_W bits, LSB first.
- Each bit: SI stable for 2*CLK_DIV cycles. CLK is low for the first CLK_DIV cycles and high for the next CLK_DIV cycles.
- After the last bit's high phase: CLK returns to 0, SI goes to 0, go to LATCH.
- Duration: DATA_W*2*CLK_DIV cycles (128 at defaults).

State LATCH:
- LE = 1 for LE_CYC cycles; SI = 0 and CLK = 0 throughout.
- last_word updates on LATCH entry. Then go to SETTLE.

State SETTLE:
- Counts SETTLE_CYC cycles with all pins at 0.
- done_pulse = 1 in the final SETTLE cycle; next state IDLE.
- busy drops in the cycle after done_pulse, i.e. on IDLE entry.
- The earliest next grant is that IDLE cycle.

Requests and inputs while busy:
- req_valid arriving while busy is held off (req_ready 0) and is not lost; it is served in rr order.
- req_data changes after accept have no effect.

Other rules:
- Redundant write: if the winner's word equals last_word and a write has completed since reset, the request is still accepted. It goes directly to SETTLE with SETTLE_CYC forced to 1, so no pins toggle. done_pulse fires in the cycle after accept.
- Bit and settle counters use saturating compare against parameter values; there is no wrap-around.

Decomposition:
- Package att_pkg:
  - state enum {IDLE, SHIFT, LATCH, SETTLE};
  - ATT_DATA_W = 16;
  - default timing constants CLK_DIV, LE_CYC, SETTLE_CYC;
  - clog2 helper.
- Sub-module att_rr_arbiter: N_REQ-wide round-robin, combinational grant from (req, pointer).

Test Plan:
- Single request: req_valid[0] = 1 with word 16'hA5C3. Expect:
  - req_ready[0] for 1 cycle;
  - SI sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (LSB first);
  - 16 CLK rising edges, each 4 cycles apart from bit start;
  - LE high for 2 cycles;
  - done_pulse 4000 cycles after LE falls;
  - last_word = 16'hA5C3.
- Contention: req_valid = 4'b1111 held, 4 distinct words. Expect grants 0,1,2,3,0,... and each word appearing on SI in that order. Back-to-back grants are separated by exactly one IDLE cycle after done_pulse.
- Request during busy: raise req_valid[2] mid-SHIFT of requester 1. Expect req_ready[2] only in the IDLE cycle after done_pulse, and no pin activity overlapping the settle window.
- Redundant write: write 16'h0010 twice from requester 3. Expect the second write to toggle no pins, with done_pulse in the cycle after req_ready.
- Reset mid-SHIFT: deassert S_AXI_ARESETN after bit 7. Expect SI/CLK/LE/busy = 0 immediately, no LE pulse, last_word = 0. After release, a fresh request completes normally.
- Parameter sweep with CLK_DIV = 1, SETTLE_CYC = 1. Expect a shift of 32 cycles and done_pulse in the cycle after LE falls.
